// File: rtl/pll_phase_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : pll_phase_pkg                                                   |
// | Purpose  : Shared types and constants for the PLL dynamic phase-shift      |
// |            sequencer: FSM state encoding, default widths, burst sizing.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pll_phase_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PULSE   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_FIN     = 3'd5
  } phase_state_t;

  // Default configuration of the sequencer
  localparam int DEF_N_OUTCLK = 5;
  localparam int DEF_CNTSEL_W = 5;
  localparam int DEF_NSTEP_W  = 3;
  localparam int DEF_REQ_W    = 16;
  localparam int DEF_TMO_CYC  = 1024;

  // Output counter C<n> is addressed by cntsel = n + CNTSEL_BASE
  localparam int CNTSEL_BASE  = 0;

  // Largest number of steps the PLL accepts in one phase_en burst
  function automatic int max_burst(input int nstep_w);
    return (1 << nstep_w) - 1;
  endfunction

  // Width of a counter index; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_phase_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pll_phase_acc                                                   |
// | Purpose  : Bank of per-output signed phase accumulators. Each completed    |
// |            burst adds +/-magnitude to the addressed entry (wrap-around).   |
// |            A clear request zeroes every entry and wins over an add.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pll_phase_acc
  import pll_phase_pkg::*;
#(
  parameter int N_OUTCLK = DEF_N_OUTCLK,
  parameter int SEL_W    = sel_width(DEF_N_OUTCLK),
  parameter int NSTEP_W  = DEF_NSTEP_W,
  parameter int ACC_W    = DEF_REQ_W + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add_en,
  input  logic [SEL_W-1:0]   add_sel,
  input  logic               add_updn,
  input  logic [NSTEP_W-1:0] add_mag,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic [ACC_W-1:0]   rd_val
);

  logic [ACC_W-1:0] acc_r [N_OUTCLK];
  logic [ACC_W-1:0] delta;

  // Later shifts count positive, earlier shifts negative (two's complement)
  assign delta = add_updn ? ACC_W'(add_mag) : (~ACC_W'(add_mag) + ACC_W'(1));

  // Accumulator update: reset/clear zero everything, otherwise add to one entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OUTCLK; i++) acc_r[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_OUTCLK; i++) acc_r[i] <= '0;
    end else if (add_en) begin
      for (int i = 0; i < N_OUTCLK; i++) begin
        if (add_sel == SEL_W'(i)) acc_r[i] <= acc_r[i] + delta;
      end
    end
  end

  // Read mux; out-of-range indices read as zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_OUTCLK; i++) begin
      if (rd_sel == SEL_W'(i)) rd_val = acc_r[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/pll_phase_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pll_phase_step_ctrl                                             |
// | Purpose  : Dynamic phase-shift sequencer for fPLL/IOPLL reconfig pins.     |
// |            Takes signed step requests, splits them into bursts of at most  |
// |            2**NSTEP_W-1 steps, pulses phase_en and tracks phase_done, with |
// |            per-burst timeout and lock-loss abort.                          |
// |            Optional macro PLL_PHASE_ACC_EN adds per-output accumulators    |
// |            readable through acc_sel/acc_val, cleared by acc_clr.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pll_phase_step_ctrl
  import pll_phase_pkg::*;
#(
  parameter  int N_OUTCLK = DEF_N_OUTCLK,
  parameter  int CNTSEL_W = DEF_CNTSEL_W,
  parameter  int NSTEP_W  = DEF_NSTEP_W,
  parameter  int REQ_W    = DEF_REQ_W,
  parameter  int TMO_CYC  = DEF_TMO_CYC,
  localparam int SEL_W    = sel_width(N_OUTCLK)
) (
  input  logic                    scanclk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SEL_W-1:0]        req_sel,
  input  logic signed [REQ_W-1:0] req_steps,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    pll_locked,
  output logic                    phase_en,
  output logic                    updn,
  output logic [CNTSEL_W-1:0]     cntsel,
  output logic [NSTEP_W-1:0]      num_phase_shifts,
  input  logic                    phase_done
`ifdef PLL_PHASE_ACC_EN
  ,
  input  logic [SEL_W-1:0]        acc_sel,
  output logic [REQ_W+3:0]        acc_val,
  input  logic                    acc_clr
`endif
);

  localparam int                 TMO_W    = $clog2(TMO_CYC) + 1;
  localparam int                 MAXB     = max_burst(NSTEP_W);
  localparam logic [REQ_W-1:0]   MAXB_REQ = REQ_W'(MAXB);
  localparam logic [NSTEP_W-1:0] MAXB_N   = NSTEP_W'(MAXB);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TMO_CYC - 1);

  phase_state_t       state;
  phase_state_t       state_nxt;

  logic               ready_init;
  logic [SEL_W-1:0]   sel_r;
  logic               updn_r;
  logic [NSTEP_W-1:0] nps_r;
  logic [REQ_W-1:0]   rem_r;
  logic [TMO_W-1:0]   tmo_r;
  logic               err_r;

  logic [REQ_W-1:0]   steps_u;
  logic [REQ_W-1:0]   steps_abs;
  logic               accept;
  logic               sel_bad;
  logic               steps_zero;
  logic               start_burst;
  logic               burst_ok;
  logic               tmo_hit;
  logic [NSTEP_W-1:0] chunk;

  // Magnitude is taken as an unsigned REQ_W value so the most negative request is legal
  assign steps_u     = req_steps;
  assign steps_abs   = steps_u[REQ_W-1] ? ((~steps_u) + REQ_W'(1)) : steps_u;
  assign steps_zero  = (steps_u == '0);
  assign sel_bad     = (32'(req_sel) >= 32'(N_OUTCLK));
  assign accept      = req_valid && req_ready;
  assign start_burst = accept && !sel_bad && !steps_zero && pll_locked;
  assign chunk       = (rem_r > MAXB_REQ) ? MAXB_N : rem_r[NSTEP_W-1:0];
  assign tmo_hit     = (tmo_r == TMO_LAST);
  // A burst counts as issued only when the PLL reports completion while still locked
  assign burst_ok    = (state == S_WAIT_HI) && phase_done && pll_locked;

  // State register
  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; lock loss anywhere mid-request aborts to FIN
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = start_burst ? S_LOAD : S_FIN;
      end
      S_LOAD:  state_nxt = S_PULSE;
      S_PULSE: state_nxt = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!phase_done)  state_nxt = S_WAIT_HI;
        else if (tmo_hit) state_nxt = S_FIN;
      end
      S_WAIT_HI: begin
        if (phase_done)   state_nxt = (rem_r != '0) ? S_LOAD : S_FIN;
        else if (tmo_hit) state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if ((state != S_IDLE) && (state != S_FIN) && !pll_locked) state_nxt = S_FIN;
  end

  // Output decode from state and held burst registers
  always_comb begin
    req_ready        = ready_init && (state == S_IDLE);
    busy             = (state != S_IDLE);
    done             = (state == S_FIN);
    err              = (state == S_FIN) && err_r;
    phase_en         = (state == S_PULSE) && pll_locked;
    updn             = updn_r;
    cntsel           = CNTSEL_W'(sel_r) + CNTSEL_W'(CNTSEL_BASE);
    num_phase_shifts = nps_r;
  end

  // Request datapath: latch request, size bursts, count remaining steps and timeout
  always_ff @(posedge scanclk or posedge rst) begin
    if (rst) begin
      ready_init <= 1'b0;
      sel_r      <= '0;
      updn_r     <= 1'b0;
      nps_r      <= '0;
      rem_r      <= '0;
      tmo_r      <= '0;
      err_r      <= 1'b0;
    end else begin
      ready_init <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            err_r <= sel_bad || !pll_locked;
            tmo_r <= '0;
            if (start_burst) begin
              sel_r  <= req_sel;
              updn_r <= (req_steps > 0);
              rem_r  <= steps_abs;
            end
          end
        end
        S_LOAD:  nps_r <= chunk;
        S_PULSE: begin
          rem_r <= rem_r - REQ_W'(nps_r);
          tmo_r <= '0;
        end
        S_WAIT_LO, S_WAIT_HI: tmo_r <= tmo_r + TMO_W'(1);
        default: ;
      endcase
      // Any exit to FIN other than a clean final burst reports an error
      if ((state != S_IDLE) && (state != S_FIN) && (state_nxt == S_FIN))
        err_r <= !(burst_ok && (rem_r == '0));
    end
  end

`ifdef PLL_PHASE_ACC_EN
  pll_phase_acc #(
    .N_OUTCLK (N_OUTCLK),
    .SEL_W    (SEL_W),
    .NSTEP_W  (NSTEP_W),
    .ACC_W    (REQ_W + 4)
  ) u_acc (
    .clk      (scanclk),
    .rst      (rst),
    .clr      (acc_clr),
    .add_en   (burst_ok),
    .add_sel  (sel_r),
    .add_updn (updn_r),
    .add_mag  (nps_r),
    .rd_sel   (acc_sel),
    .rd_val   (acc_val)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pll_phase_step_ctrl                                          |
// | Purpose  : Self-checking bench for pll_phase_step_ctrl with a simple PLL   |
// |            phase_done model and an expected-result queue.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pll_phase_step_ctrl;

  localparam int N_OUTCLK = 5;
  localparam int CNTSEL_W = 5;
  localparam int NSTEP_W  = 3;
  localparam int REQ_W    = 16;
  localparam int TMO_CYC  = 64;
  localparam int SEL_W    = 3;
  localparam int ACC_W    = REQ_W + 4;

  logic                    scanclk = 1'b0;
  logic                    rst = 1'b1;
  logic                    req_valid = 1'b0;
  logic [SEL_W-1:0]        req_sel = '0;
  logic signed [REQ_W-1:0] req_steps = '0;
  logic                    pll_locked = 1'b1;
  logic                    phase_done = 1'b1;
  logic                    req_ready, busy, done, err, phase_en, updn;
  logic [CNTSEL_W-1:0]     cntsel;
  logic [NSTEP_W-1:0]      num_phase_shifts;
`ifdef PLL_PHASE_ACC_EN
  logic [SEL_W-1:0]        acc_sel = '0;
  logic [ACC_W-1:0]        acc_val;
  logic                    acc_clr = 1'b0;
`endif

  pll_phase_step_ctrl #(
    .N_OUTCLK(N_OUTCLK), .CNTSEL_W(CNTSEL_W), .NSTEP_W(NSTEP_W),
    .REQ_W(REQ_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .scanclk(scanclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_steps(req_steps), .busy(busy), .done(done), .err(err),
    .pll_locked(pll_locked), .phase_en(phase_en), .updn(updn), .cntsel(cntsel),
    .num_phase_shifts(num_phase_shifts), .phase_done(phase_done)
`ifdef PLL_PHASE_ACC_EN
    , .acc_sel(acc_sel), .acc_val(acc_val), .acc_clr(acc_clr)
`endif
  );

  always #5 scanclk = ~scanclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { bit err; int pulses; } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string                   name;
    logic [SEL_W-1:0]        sel;
    logic signed [REQ_W-1:0] steps;
    bit                      exp_err;
    int                      exp_pulses;
    int                      exp_lat;   // 0 = latency not checked
  } vec_t;
  vec_t vecs[8];

  // Request currently in flight, as the bench expects it to be issued
  int cur_sel = 0;
  int cur_rem = 0;
  bit cur_updn = 1'b0;
  int pulses = 0;

  // PLL model control
  bit stuck = 1'b0;
  bit pbusy = 1'b0;
  int pcnt = 0;
  int pnps = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge scanclk) cyc <= cyc + 1;

  // PLL model: phase_done low 2 cycles after phase_en, high after 4*num_phase_shifts
  always @(negedge scanclk or posedge rst) begin
    if (rst) begin
      phase_done <= 1'b1;
      pbusy      <= 1'b0;
      pcnt       <= 0;
    end else if (pbusy) begin
      pcnt <= pcnt + 1;
      if (pcnt + 1 == 2) phase_done <= 1'b0;
      if (pcnt + 1 >= 4 * pnps) begin
        phase_done <= 1'b1;
        pbusy      <= 1'b0;
      end
    end else if (phase_en && !stuck) begin
      pbusy <= 1'b1;
      pcnt  <= 0;
      pnps  <= int'(num_phase_shifts);
    end
  end

  // Monitor: per-burst settings at each phase_en, scoreboard pop at each done
  always @(negedge scanclk) begin
    int chunk;
    exp_t e;
    if (!rst) begin
      if (phase_en) begin
        chunk = (cur_rem > 7) ? 7 : cur_rem;
        cur_rem = cur_rem - chunk;
        pulses = pulses + 1;
        check("burst_nps", num_phase_shifts, chunk);
        check("burst_updn", updn, cur_updn);
        check("burst_cntsel", cntsel, cur_sel);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          e = sb_q.pop_front();
          check("done_err", err, e.err);
          check("pulse_count", pulses, e.pulses);
        end
        pulses = 0;
      end
    end
  end

  task automatic tick();
    @(posedge scanclk);
    #1;
  endtask

  task automatic issue(input logic [SEL_W-1:0] sel, input logic signed [REQ_W-1:0] steps,
                       input bit exp_err, input int exp_pulses);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 200) begin tick(); n++; end
    check("ready_before_req", req_ready, 1);
    cur_sel  = int'(sel);
    cur_updn = (steps > 0);
    cur_rem  = (steps < 0) ? -int'(steps) : int'(steps);
    e.err = exp_err;
    e.pulses = exp_pulses;
    sb_q.push_back(e);
    req_sel   = sel;
    req_steps = steps;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ready_drop", req_ready, 0);
  endtask

  // Wait for done (bounded), return cycles after accept, then check return to idle
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 3000) begin tick(); lat++; end
    check("done_seen", done, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_ready", req_ready, 1);
    check("idle_busy", busy, 0);
  endtask

`ifdef PLL_PHASE_ACC_EN
  task automatic check_acc(input string name, input int sel, input longint exp);
    acc_sel = SEL_W'(sel);
    #1;
    check(name, longint'($signed(acc_val)), exp);
  endtask
`endif

  initial begin
    int lat, n, t0;
    vecs[0] = '{"p5_sel2",   3'd2,   16'sd5, 1'b0, 1, 0};
    vecs[1] = '{"m20_sel0",  3'd0,  -16'sd20, 1'b0, 3, 0};
    vecs[2] = '{"zero_sel1", 3'd1,   16'sd0, 1'b0, 0, 1};
    vecs[3] = '{"bad_sel7",  3'd7,   16'sd3, 1'b1, 0, 1};
    vecs[4] = '{"p7_sel4",   3'd4,   16'sd7, 1'b0, 1, 0};
    vecs[5] = '{"m8_sel3",   3'd3,   -16'sd8, 1'b0, 2, 0};
    vecs[6] = '{"p15_sel1",  3'd1,  16'sd15, 1'b0, 3, 0};
    vecs[7] = '{"bad_sel5",  3'd5,  -16'sd9, 1'b1, 0, 1};

    // Reset state
    repeat (3) tick();
    check("rst_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_phase_en", phase_en, 0);
    check("rst_cntsel", cntsel, 0);
    check("rst_nps", num_phase_shifts, 0);
    rst = 1'b0;
    check("rel_ready_0", req_ready, 0);
    tick();
    check("rel_ready_1", req_ready, 1);

    // Table-driven requests
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].sel, vecs[i].steps, vecs[i].exp_err, vecs[i].exp_pulses);
      wait_done(lat);
      if (vecs[i].exp_lat != 0) check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
    end

`ifdef PLL_PHASE_ACC_EN
    check_acc("acc0", 0, -20);
    check_acc("acc1", 1, 15);
    check_acc("acc2", 2, 5);
    check_acc("acc3", 3, -8);
    check_acc("acc4", 4, 7);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check_acc("acc_clr0", 0, 0);
    check_acc("acc_clr3", 3, 0);
`endif

    // Lock loss during WAIT_HI of the second burst of +30
    issue(3'd3, 16'sd30, 1'b1, 2);
    n = 0;
    while (pulses < 2 && n < 200) begin tick(); n++; end
    check("lock_second_pulse", pulses, 2);
    n = 0;
    while (phase_done && n < 20) begin tick(); n++; end
    check("lock_pd_low", phase_done, 0);
    tick();
    tick();
    pll_locked = 1'b0;
    tick();
    check("lock_done", done, 1);
    check("lock_err", err, 1);
    check("lock_phase_en", phase_en, 0);
    tick();
    pll_locked = 1'b1;
    n = 0;
    while (pbusy && n < 100) begin tick(); n++; end
`ifdef PLL_PHASE_ACC_EN
    check_acc("lock_acc3", 3, 7);
`endif

    // Request while unlocked in IDLE
    pll_locked = 1'b0;
    issue(3'd1, 16'sd4, 1'b1, 0);
    wait_done(lat);
    check("unlocked_lat", lat, 1);
    pll_locked = 1'b1;

    // Timeout: PLL never drops phase_done
    stuck = 1'b1;
    issue(3'd1, 16'sd3, 1'b1, 1);
    n = 0;
    while (!phase_en && n < 20) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check("tmo_done", done, 1);
    check("tmo_window", ((cyc - t0) >= TMO_CYC - 1) && ((cyc - t0) <= TMO_CYC + 2), 1);
    tick();
    stuck = 1'b0;

    // Asynchronous reset in the middle of a burst
    issue(3'd2, 16'sd20, 1'b0, 3);
    n = 0;
    while (pulses < 1 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    check("arst_phase_en", phase_en, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_updn", updn, 0);
    check("arst_cntsel", cntsel, 0);
    check("arst_nps", num_phase_shifts, 0);
    check("arst_ready", req_ready, 0);
    sb_q.delete();
    pulses = 0;
    tick();
    rst = 1'b0;
    check("arst_rel_ready_0", req_ready, 0);
    tick();
    check("arst_rel_ready_1", req_ready, 1);
`ifdef PLL_PHASE_ACC_EN
    check_acc("arst_acc2", 2, 0);
    check_acc("arst_acc3", 3, 0);
`endif
    repeat (5) tick();
    check("arst_no_done", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
